// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the N-channel line-memory arbiter.
// Imported by the pick logic and by mem_line_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int DEF_LINE_W = 128;
  localparam int DEF_ADDR_W = 28;

  // Width of a channel index; a single channel still needs one bit to hold index 0.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: round-robin scan from rr_ptr (wrapping),
// or fixed priority with channel 0 highest.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int IDX_W = idx_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic             mode,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic found;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    grant = '0;
    valid = |req;
    if (mode) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!found && req[i]) begin
          found = 1'b1;
          idx   = IDX_W'(i);
        end
      end
    end else begin
      // Offsets are taken modulo N_CH so the scan wraps from N_CH-1 back to 0.
      for (int off = 0; off < N_CH; off++) begin
        int j;
        j = (int'(rr_ptr) + off) % N_CH;
        if (!found && req[j]) begin
          found = 1'b1;
          idx   = IDX_W'(j);
        end
      end
    end
    if (valid) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Merges several caches' line request ports onto one slow-memory port.
// Every downstream signal is registered; channel inputs never reach the memory combinationally.
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int LINE_W   = DEF_LINE_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                     clk,
  input  logic                     proc_reset,
  input  logic [N_CH-1:0]          ch_read,
  input  logic [N_CH-1:0]          ch_write,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [N_CH-1:0]          ch_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic                     proto_err
);

  localparam int IDX_W = idx_width(N_CH);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_CH-1:0]  gnt_mask;

  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;
  logic              sel_write;
  logic [IDX_W-1:0]  rr_next;

  assign req = ch_read | ch_write;

  mem_arb_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .mode   (ARB_MODE == ARB_FIXED),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Write wins when a channel raises both read and write.
  always_comb begin
    sel_addr  = ch_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    sel_wdata = ch_wdata[int'(pick_idx)*LINE_W +: LINE_W];
    sel_write = ch_write[pick_idx];
  end

  assign rr_next = (gnt_idx == IDX_W'(N_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      gnt_mask  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ch_ready  <= '0;
      ch_rdata  <= '0;
      proto_err <= 1'b0;
    end else begin
      ch_ready <= '0;
      if (|(ch_read & ch_write)) begin
        proto_err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_idx   <= pick_idx;
            gnt_mask  <= pick_grant;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_write <= sel_write;
            mem_read  <= !sel_write;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Read data is only captured for reads so writes leave ch_rdata untouched.
          if (mem_ready) begin
            if (!mem_write) begin
              ch_rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ch_ready  <= gnt_mask;
            state     <= RESP;
          end
        end
        RESP: begin
          if (ARB_MODE == ARB_RR) begin
            rr_ptr <= rr_next;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench: a 3-channel round-robin arbiter and a 2-channel fixed-priority one,
// each backed by a small memory responder that can run automatically or be fired by hand.
module tb_mem_line_arbiter;

  logic clk = 1'b0;
  logic proc_reset;

  logic [2:0]      rr_read, rr_write, rr_ready;
  logic [83:0]     rr_addr;
  logic [383:0]    rr_wdata;
  logic [127:0]    rr_rdata, rr_mwdata, rr_mrdata;
  logic            rr_mread, rr_mwrite, rr_mready, rr_perr;
  logic [27:0]     rr_maddr;

  logic [1:0]      fp_read, fp_write, fp_ready;
  logic [55:0]     fp_addr;
  logic [255:0]    fp_wdata;
  logic [127:0]    fp_rdata, fp_mwdata, fp_mrdata;
  logic            fp_mread, fp_mwrite, fp_mready, fp_perr;
  logic [27:0]     fp_maddr;

  bit              rr_auto, rr_man_fire;
  logic [127:0]    rr_man_data;
  int              rr_lat, rr_cnt, fp_cnt;

  int              compared = 0;
  int              mismatched = 0;
  int              glog[$];

  always #5 clk = ~clk;

  mem_line_arbiter #(.N_CH(3), .LINE_W(128), .ADDR_W(28), .ARB_MODE(0)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .ch_read(rr_read), .ch_write(rr_write), .ch_addr(rr_addr), .ch_wdata(rr_wdata),
    .ch_rdata(rr_rdata), .ch_ready(rr_ready),
    .mem_read(rr_mread), .mem_write(rr_mwrite), .mem_addr(rr_maddr), .mem_wdata(rr_mwdata),
    .mem_rdata(rr_mrdata), .mem_ready(rr_mready), .proto_err(rr_perr)
  );

  mem_line_arbiter #(.N_CH(2), .LINE_W(128), .ADDR_W(28), .ARB_MODE(1)) dut_fp (
    .clk(clk), .proc_reset(proc_reset),
    .ch_read(fp_read), .ch_write(fp_write), .ch_addr(fp_addr), .ch_wdata(fp_wdata),
    .ch_rdata(fp_rdata), .ch_ready(fp_ready),
    .mem_read(fp_mread), .mem_write(fp_mwrite), .mem_addr(fp_maddr), .mem_wdata(fp_mwdata),
    .mem_rdata(fp_mrdata), .mem_ready(fp_mready), .proto_err(fp_perr)
  );

  // Memory content is a fixed pattern of the line address so expected read data is computable.
  function automatic logic [127:0] lineOf(input logic [27:0] a);
    return {4'hA, a, 4'hB, a, 4'hC, a, 4'hD, a};
  endfunction

  function automatic int idxOf(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic int gAt(input int i);
    return (glog.size() > i) ? glog[i] : -1;
  endfunction

  // Responders act on the falling edge so the arbiter samples settled values.
  always @(negedge clk) begin
    if (rr_auto) begin
      if (rr_mready) begin
        rr_mready = 1'b0;
      end else if (rr_mread || rr_mwrite) begin
        rr_cnt++;
        if (rr_cnt >= rr_lat) begin
          rr_mready = 1'b1;
          rr_mrdata = lineOf(rr_maddr);
          rr_cnt = 0;
        end
      end
    end else begin
      rr_cnt = 0;
      rr_mready = rr_man_fire;
      rr_mrdata = rr_man_data;
    end
  end

  always @(negedge clk) begin
    if (fp_mready) begin
      fp_mready = 1'b0;
    end else if (fp_mread || fp_mwrite) begin
      fp_cnt++;
      if (fp_cnt >= 1) begin
        fp_mready = 1'b1;
        fp_mrdata = lineOf(fp_maddr);
        fp_cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
  endtask

  task automatic applyStimulus(input int ch, input logic rd, input logic wr,
                               input logic [27:0] addr, input logic [127:0] wdata);
    rr_read[ch]              = rd;
    rr_write[ch]             = wr;
    rr_addr[ch*28 +: 28]     = addr;
    rr_wdata[ch*128 +: 128]  = wdata;
  endtask

  task automatic memRespond(input logic [127:0] data);
    rr_man_data = data;
    rr_man_fire = 1'b1;
    tick();
    rr_man_fire = 1'b0;
  endtask

  // Logs ready pulses; on the n-th, request bits outside 'keep' drop during the RESP cycle.
  task automatic collectGrants(input bit useFp, input int n, input logic [2:0] keep);
    int seen;
    logic [2:0] rdy;
    logic [1:0] busy;
    seen = 0;
    glog.delete();
    for (int c = 0; c < 400 && seen < n; c++) begin
      tick();
      rdy  = useFp ? {1'b0, fp_ready} : rr_ready;
      busy = useFp ? {fp_mread, fp_mwrite} : {rr_mread, rr_mwrite};
      if (|rdy) begin
        glog.push_back(idxOf(rdy));
        checkOutput("gap_on_ready", {126'd0, busy}, 128'd0);
        seen++;
        if (seen == n) begin
          if (useFp) begin
            fp_read  = fp_read & keep[1:0];
            fp_write = fp_write & keep[1:0];
          end else begin
            rr_read  = rr_read & keep;
            rr_write = rr_write & keep;
          end
        end
      end
    end
    checkOutput("grant_count", 128'(seen), 128'(n));
  endtask

  initial begin
    proc_reset = 1'b1;
    rr_read = '0; rr_write = '0; rr_addr = '0; rr_wdata = '0;
    fp_read = '0; fp_write = '0; fp_addr = '0; fp_wdata = '0;
    rr_auto = 1'b0; rr_man_fire = 1'b0; rr_man_data = '0; rr_lat = 2;
    rr_cnt = 0; fp_cnt = 0; rr_mready = 1'b0; rr_mrdata = '0;
    fp_mready = 1'b0; fp_mrdata = '0;
    tick();
    tick();
    checkOutput("rst_mem_req", {126'd0, rr_mread, rr_mwrite}, 128'd0);
    checkOutput("rst_ready", 128'(rr_ready), 128'd0);
    checkOutput("rst_rdata", rr_rdata, 128'd0);
    checkOutput("rst_addr", 128'(rr_maddr), 128'd0);
    checkOutput("rst_perr", 128'(rr_perr), 128'd0);
    checkOutput("rst_fp_req", {126'd0, fp_mread, fp_mwrite}, 128'd0);
    proc_reset = 1'b0;

    // Single read on channel 0 with a hand-timed memory response.
    applyStimulus(0, 1'b1, 1'b0, 28'h0000040, '0);
    tick();
    checkOutput("rd_mem_read", 128'(rr_mread), 128'd1);
    checkOutput("rd_mem_write", 128'(rr_mwrite), 128'd0);
    checkOutput("rd_mem_addr", 128'(rr_maddr), 128'h40);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rd_hold", {rr_mread, 99'd0, rr_maddr}, {1'b1, 99'd0, 28'h40});
    end
    memRespond(128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    checkOutput("rd_ready", 128'(rr_ready), 128'h1);
    checkOutput("rd_resp_req", {126'd0, rr_mread, rr_mwrite}, 128'd0);
    checkOutput("rd_rdata", rr_rdata, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    rr_read = '0;
    tick();
    checkOutput("rd_ready_drop", 128'(rr_ready), 128'd0);

    // Round-robin between channels 0 and 1.
    pulseReset();
    rr_auto = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 28'h100, '0);
    applyStimulus(1, 1'b1, 1'b0, 28'h200, '0);
    collectGrants(1'b0, 4, 3'b000);
    checkOutput("rr2_g0", 128'(gAt(0)), 128'd0);
    checkOutput("rr2_g1", 128'(gAt(1)), 128'd1);
    checkOutput("rr2_g2", 128'(gAt(2)), 128'd0);
    checkOutput("rr2_g3", 128'(gAt(3)), 128'd1);
    checkOutput("rr2_rdata", rr_rdata, lineOf(28'h200));

    // Three-way round-robin with wrap-around.
    pulseReset();
    applyStimulus(0, 1'b1, 1'b0, 28'h100, '0);
    applyStimulus(1, 1'b1, 1'b0, 28'h200, '0);
    applyStimulus(2, 1'b1, 1'b0, 28'h300, '0);
    collectGrants(1'b0, 4, 3'b000);
    checkOutput("rr3_g0", 128'(gAt(0)), 128'd0);
    checkOutput("rr3_g1", 128'(gAt(1)), 128'd1);
    checkOutput("rr3_g2", 128'(gAt(2)), 128'd2);
    checkOutput("rr3_g3", 128'(gAt(3)), 128'd0);
    checkOutput("rr3_rdata", rr_rdata, lineOf(28'h100));

    // Write then read on channel 1 with the mandatory idle gap.
    rr_auto = 1'b0;
    tick();
    applyStimulus(1, 1'b0, 1'b1, 28'h10, 128'h1234);
    tick();
    checkOutput("wr_mem_write", {126'd0, rr_mread, rr_mwrite}, 128'd1);
    checkOutput("wr_mem_addr", 128'(rr_maddr), 128'h10);
    checkOutput("wr_mem_wdata", rr_mwdata, 128'h1234);
    memRespond(128'hBAD);
    checkOutput("wr_ready", 128'(rr_ready), 128'h2);
    checkOutput("wr_resp_req", {126'd0, rr_mread, rr_mwrite}, 128'd0);
    checkOutput("wr_rdata_kept", rr_rdata, lineOf(28'h100));
    applyStimulus(1, 1'b1, 1'b0, 28'h20, '0);
    tick();
    checkOutput("wr_gap", {126'd0, rr_mread, rr_mwrite}, 128'd0);
    tick();
    checkOutput("wr_rd_req", {126'd0, rr_mread, rr_mwrite}, 128'd2);
    checkOutput("wr_rd_addr", 128'(rr_maddr), 128'h20);
    memRespond(128'hCAFE);
    checkOutput("wr_rd_ready", 128'(rr_ready), 128'h2);
    checkOutput("wr_rd_rdata", rr_rdata, 128'hCAFE);
    rr_read = '0;
    tick();

    // Reset during ISSUE after rr_ptr has moved off zero.
    rr_auto = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 28'h100, '0);
    collectGrants(1'b0, 1, 3'b000);
    checkOutput("abort_pre_grant", 128'(gAt(0)), 128'd0);
    rr_auto = 1'b0;
    tick();
    applyStimulus(1, 1'b1, 1'b0, 28'h200, '0);
    tick();
    checkOutput("abort_issue", {rr_mread, 99'd0, rr_maddr}, {1'b1, 99'd0, 28'h200});
    tick();
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    rr_read = '0;
    checkOutput("abort_req_low", {126'd0, rr_mread, rr_mwrite}, 128'd0);
    checkOutput("abort_no_ready", 128'(rr_ready), 128'd0);
    memRespond(128'hBAD);
    checkOutput("abort_late_ready", 128'(rr_ready), 128'd0);
    checkOutput("abort_rdata", rr_rdata, 128'd0);
    tick();
    checkOutput("abort_idle", {126'd0, rr_mread, rr_mwrite}, 128'd0);
    rr_read = 3'b011;
    tick();
    checkOutput("abort_ptr_zero", 128'(rr_maddr), 128'h100);
    rr_auto = 1'b1;
    collectGrants(1'b0, 1, 3'b000);
    checkOutput("abort_post_grant", 128'(gAt(0)), 128'd0);

    // Read and write together on one channel.
    rr_auto = 1'b0;
    tick();
    checkOutput("perr_clear", 128'(rr_perr), 128'd0);
    applyStimulus(0, 1'b1, 1'b1, 28'h50, 128'h77);
    tick();
    checkOutput("perr_is_write", {126'd0, rr_mread, rr_mwrite}, 128'd1);
    checkOutput("perr_wdata", rr_mwdata, 128'h77);
    checkOutput("perr_set", 128'(rr_perr), 128'd1);
    memRespond(128'hBAD);
    checkOutput("perr_ready", 128'(rr_ready), 128'h1);
    checkOutput("perr_rdata_kept", rr_rdata, lineOf(28'h100));
    applyStimulus(0, 1'b0, 1'b0, 28'h50, '0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("perr_sticky", 128'(rr_perr), 128'd1);
    pulseReset();
    checkOutput("perr_reset", 128'(rr_perr), 128'd0);

    // Fixed priority: channel 1 waits until channel 0 skips one IDLE cycle.
    fp_addr = {28'h222, 28'h111};
    fp_read = 2'b11;
    collectGrants(1'b1, 3, 3'b010);
    checkOutput("fp_g0", 128'(gAt(0)), 128'd0);
    checkOutput("fp_g1", 128'(gAt(1)), 128'd0);
    checkOutput("fp_g2", 128'(gAt(2)), 128'd0);
    tick();
    checkOutput("fp_idle", 128'(fp_mread), 128'd0);
    tick();
    checkOutput("fp_ch1_issue", {fp_mread, 99'd0, fp_maddr}, {1'b1, 99'd0, 28'h222});
    collectGrants(1'b1, 1, 3'b000);
    checkOutput("fp_ch1_grant", 128'(gAt(0)), 128'd1);
    checkOutput("fp_ch1_rdata", fp_rdata, lineOf(28'h222));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Parametrised N-channel line-memory arbiter. It merges the block-level (128-bit line) request ports of several caches (I-cache, D-cache, future L2/prefetch) onto one shared slow-memory port.
- Successor to the fixed one-cache-per-memory pairing: arbitration mode, channel count, and line/address widths are generics.
- Sits between the cache instances and the single external memory in the top level. It is transparent to each cache's level-held request / ready-pulse protocol.

Parameters:
- N_CH, 2, number of cache channels (1..8)
- LINE_W, 128, line data width in bits
- ADDR_W, 28, line address width (byte address bits [31:4])
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority (channel 0 highest)

Ports:
- clk  in  1  system clock, all state on rising edge
- proc_reset  in  1  synchronous, active-high reset
- ch_read  in  N_CH  per-channel read request, held until that channel's ch_ready
- ch_write  in  N_CH  per-channel write request, held until ch_ready
- ch_addr  in  N_CH*ADDR_W  packed line addresses; channel i is at [i*ADDR_W +: ADDR_W]
- ch_wdata  in  N_CH*LINE_W  packed write lines
- ch_rdata  out  LINE_W  read line, shared by all channels, valid when any ch_ready is high
- ch_ready  out  N_CH  one-hot, one-cycle completion pulse
- mem_read  out  1  downstream read request
- mem_write  out  1  downstream write request
- mem_addr  out  ADDR_W  downstream line address
- mem_wdata  out  LINE_W  downstream write line
- mem_rdata  in  LINE_W  downstream read line, valid with mem_ready
- mem_ready  in  1  downstream completion pulse
- proto_err  out  1  sticky flag: a channel asserted read and write in the same cycle

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; rr_ptr = 0; grant register cleared.
  - All outputs 0: mem_read/mem_write/mem_addr/mem_wdata, ch_ready, ch_rdata, proto_err.
  - Reset asserted mid-transaction aborts it: downstream request is low in the cycle after reset is sampled, and no ch_ready is issued for the aborted transaction.
- States: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - req[i] = ch_read[i] | ch_write[i].
  - If any req is set, pick winner k:
    - ARB_MODE 0: first requesting channel scanning from rr_ptr upward, wrapping N_CH-1 -> 0.
    - ARB_MODE 1: lowest requesting index.
  - Register k, its address, its wdata, and op (write if ch_write[k], else read). Go to ISSUE.
  - If no req is set, stay in IDLE.
- ISSUE:
  - mem_read/mem_write, mem_addr, and mem_wdata are driven from registers only. They never combinationally follow ch_* inputs.
  - Held stable until mem_ready = 1. On mem_ready: capture mem_rdata into ch_rdata, go to RESP.
  - No timeout; the arbiter waits indefinitely for mem_ready.
- RESP:
  - ch_ready[k] = 1 for exactly this cycle; mem_read/mem_write = 0.
  - ARB_MODE 0: rr_ptr = (k+1) mod N_CH.
  - Go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle T -> mem_read/mem_write high at T+1.
  - mem_ready at cycle R -> ch_ready at R+1.
  - Minimum turnaround: 3 cycles plus memory latency.
- Downstream request always has at least one low cycle (RESP) between back-to-back transactions.
- The winning channel's request is still high during RESP. By the following IDLE cycle it is deasserted or re-asserted for a new operation (e.g. a cache going from write-back to allocate); the latter is treated as a fresh request.
- Non-granted channels keep their requests held. ch_ready stays 0 for them.
- Read and write both high on one channel: write is chosen, proto_err is set, and proto_err stays set until reset.
- ch_rdata holds its last captured value between transactions. It is not updated on writes.
- N_CH = 1: arbitration degenerates to pass-through with a registered stage. rr_ptr stays 0.
- Starvation bound (mode 0): a continuously requesting channel is granted within N_CH transactions. Mode 1 has no bound.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, RESP)
  - ARB_RR / ARB_FIXED mode constants
  - default LINE_W / ADDR_W localparams
- Sub-module mem_arb_pick: combinational pick logic.
  - Inputs: req vector, rr_ptr, mode. Outputs: one-hot grant, encoded index, valid.
  - Instantiated once. The rest (FSM, registers) stays in mem_line_arbiter.

Test Plan:
- Single read:
  - Stimulus: ch_read = 01, ch_addr[0] = 28'h0000040; memory returns 128'hDEAD..BEEF after 4 cycles.
  - Required: mem_read high at T+1 with mem_addr = 28'h0000040; ch_ready = 01 one cycle after mem_ready; ch_rdata = DEAD..BEEF.
- Simultaneous requests, round-robin:
  - Stimulus: ARB_MODE 0, ch_read = 11 held continuously, re-asserted after each ready.
  - Required: grants alternate 0, 1, 0, 1.
  - Repeat with N_CH = 3, all requesting: order 0, 1, 2, 0 (wrap-around).
- Fixed priority:
  - Stimulus: ARB_MODE 1, ch0 re-requests immediately after each ready, ch1 held.
  - Required: ch1 never granted while ch0 requests; ch1 granted as soon as ch0 idles for one IDLE cycle.
- Write then read from same channel:
  - Stimulus: ch_write[1] with wdata 128'h1234 at addr 28'h10, then ch_read[1] at addr 28'h20.
  - Required: mem_write with correct data; a one-cycle gap with mem_read/mem_write = 0; then mem_read at addr 28'h20; ch_rdata unchanged by the write.
- Reset mid-transaction:
  - Stimulus: proc_reset pulsed while in ISSUE, before mem_ready.
  - Required: next cycle mem_read = 0 and ch_ready = 0; a later mem_ready for the aborted transaction is ignored; rr_ptr = 0 afterwards.
- Protocol error:
  - Stimulus: ch_read[0] = ch_write[0] = 1.
  - Required: a write is issued; proto_err = 1 and stays 1 until proc_reset.
